dmem_responder: RTL

- Memory-side responder for the CPU data-memory port.
- Accepts one load/store request through a valid/ready handshake, waits a fixed number of cycles, then performs the access.
- Returns one response: read data plus an error flag.
- Lets the core be exercised against a memory that has latency, in place of the zero-latency Data_Memory.

---
 rtl/dmem_responder_pkg.sv | 12 +
 rtl/dmem_word_array.sv | 25 ++
 rtl/dmem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the latency-modelling data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int BYTE_OFFSET_WIDTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage: synchronous write, asynchronous read, no reset.
module dmem_word_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int INDEX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                   clk,
  input  logic                   write_en,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [WORD_WIDTH-1:0]  wdata,
  output logic [WORD_WIDTH-1:0]  rdata
);

  logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, then performs
// the access and returns a single-cycle response with read data and error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W     = ADDR_WIDTH - BYTE_OFFSET_WIDTH;
  localparam int ARR_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  // One extra bit keeps the range limit representable even when DEPTH_WORDS
  // equals the full index space.
  localparam logic [IDX_W:0]   DEPTH_LIMIT = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(WAIT_CYCLES);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        cnt;
  logic                    cap_write;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [WORD_WIDTH-1:0]   cap_wdata;
  logic [IDX_W-1:0]        word_index;
  logic                    addr_err;
  logic                    access_fire;
  logic [WORD_WIDTH-1:0]   mem_rdata;

  assign word_index = cap_addr[ADDR_WIDTH-1:BYTE_OFFSET_WIDTH];
  assign addr_err   = (cap_addr[BYTE_OFFSET_WIDTH-1:0] != '0) ||
                      ({1'b0, word_index} >= DEPTH_LIMIT);
  assign req_ready  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    access_fire = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          access_fire = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, wait countdown and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= access_fire;
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cnt       <= CNT_LOAD;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access_fire) begin
        rsp_err   <= addr_err;
        rsp_rdata <= (addr_err || cap_write) ? '0 : mem_rdata;
      end
    end
  end

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INDEX_WIDTH (ARR_IDX_W)
  ) u_word_array (
    .clk      (clk),
    .write_en (access_fire && cap_write && !addr_err),
    .index    (word_index[ARR_IDX_W-1:0]),
    .wdata    (cap_wdata),
    .rdata    (mem_rdata)
  );

endmodule
